// File: rtl/rob_commit_pkg.sv
// Shared types and sizing for the Gambit ROB retirement stage.
package rob_commit_pkg;

    localparam int RENTRIES = 16;
    localparam int RSLOTS   = 2;
    localparam int RID_W    = $clog2(RENTRIES);

    typedef logic [RID_W-1:0]    rid_t;
    typedef logic [RENTRIES-1:0] rmask_t;
    typedef logic [RSLOTS-1:0]   slot_mask_t;
    typedef logic [2:0]          cnt_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_EXC_WAIT,
        ST_FLUSH
    } commit_state_t;

endpackage

// File: rtl/rob_commit_if.sv
// Retirement bus between the ROB allocation side and the commit stage.
// Optional ROB_COMMIT_PERF_EN adds the commit_total_o counter signal.
interface rob_commit_if;
    import rob_commit_pkg::*;

    rmask_t                 rob_v_i;
    rmask_t                 rob_done_i;
    rmask_t                 rob_exc_i;
    rid_t                   rob_tail_i;
    logic                   exc_ack_i;

    rid_t                   rob_head_o;
    rmask_t                 rob_clr_o;
    slot_mask_t             commit_v_o;
    rid_t [RSLOTS-1:0]      commit_rid_o;
    cnt_t                   commitCnt;
    logic                   exc_req_o;
    rid_t                   exc_rid_o;
`ifdef ROB_COMMIT_PERF_EN
    logic [63:0]            commit_total_o;
`endif

    // Commit stage side.
    modport master (
`ifdef ROB_COMMIT_PERF_EN
        output commit_total_o,
`endif
        input  rob_v_i, rob_done_i, rob_exc_i, rob_tail_i, exc_ack_i,
        output rob_head_o, rob_clr_o, commit_v_o, commit_rid_o, commitCnt,
        output exc_req_o, exc_rid_o
    );

    // Allocation / exception handler side.
    modport slave (
`ifdef ROB_COMMIT_PERF_EN
        input  commit_total_o,
`endif
        output rob_v_i, rob_done_i, rob_exc_i, rob_tail_i, exc_ack_i,
        input  rob_head_o, rob_clr_o, commit_v_o, commit_rid_o, commitCnt,
        input  exc_req_o, exc_rid_o
    );

endinterface

// File: rtl/rob_commit_select.sv
// Combinational retirement-group selection over the RSLOTS-entry window at head.
module rob_commit_select
    import rob_commit_pkg::*;
(
    input  rid_t       head,
    input  rmask_t     valid,
    input  rmask_t     done,
    input  rmask_t     exc,
    output slot_mask_t retire,
    output cnt_t       count,
    output logic       exc_head
);

    logic open;
    rid_t e;

    // Walk the window in order; the first entry that cannot retire closes the group.
    always_comb begin
        open   = 1'b1;
        e      = head;
        retire = '0;
        count  = '0;
        for (int k = 0; k < RSLOTS; k++) begin
            e = head + rid_t'(k);
            if (open && valid[e] && done[e] && !exc[e]) begin
                retire[k] = 1'b1;
                count     = count + cnt_t'(1);
            end else begin
                open = 1'b0;
            end
        end
        exc_head = valid[head] && done[head] && exc[head];
    end

endmodule

// File: rtl/rob_commit.sv
// In-order ROB retirement stage: retire FSM, head pointer and registered outputs.
// Optional ROB_COMMIT_PERF_EN adds a 64-bit retirement counter on commit_total_o.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rob_commit_if.master  bus
);

    commit_state_t     state, state_d;
    rid_t              head_q, head_d;
    rmask_t            clr_q, clr_d;
    slot_mask_t        cv_q, cv_d;
    rid_t [RSLOTS-1:0] rid_q, rid_d;
    cnt_t              cnt_q, cnt_d;
    logic              req_q, req_d;
    rid_t              erid_q, erid_d;

    rmask_t            valid_eff;
    slot_mask_t        retire;
    cnt_t              count;
    logic              exc_head;
    rid_t              slot_e;

    // Entries cleared last edge may still read valid upstream this cycle; hide them.
    assign valid_eff = bus.rob_v_i & ~clr_q;

    rob_commit_select u_select (
        .head     (head_q),
        .valid    (valid_eff),
        .done     (bus.rob_done_i),
        .exc      (bus.rob_exc_i),
        .retire   (retire),
        .count    (count),
        .exc_head (exc_head)
    );

    // State, head and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            head_q <= '0;
            clr_q  <= '0;
            cv_q   <= '0;
            rid_q  <= '0;
            cnt_q  <= '0;
            req_q  <= 1'b0;
            erid_q <= '0;
        end else begin
            state  <= state_d;
            head_q <= head_d;
            clr_q  <= clr_d;
            cv_q   <= cv_d;
            rid_q  <= rid_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            erid_q <= erid_d;
        end
    end

    // Next-state: an exception at head parks in EXC_WAIT until acked, then one flush cycle.
    always_comb begin
        state_d = state;
        case (state)
            ST_RUN:      if (exc_head) state_d = ST_EXC_WAIT;
            ST_EXC_WAIT: if (bus.exc_ack_i) state_d = ST_FLUSH;
            ST_FLUSH:    state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // Next output values; retirement pulses default to zero every cycle.
    always_comb begin
        head_d = head_q;
        clr_d  = '0;
        cv_d   = '0;
        rid_d  = '0;
        cnt_d  = '0;
        req_d  = req_q;
        erid_d = erid_q;
        slot_e = head_q;
        case (state)
            ST_RUN: begin
                cv_d   = retire;
                cnt_d  = count;
                head_d = head_q + rid_t'(count);
                for (int k = 0; k < RSLOTS; k++) begin
                    slot_e = head_q + rid_t'(k);
                    if (retire[k]) begin
                        rid_d[k]      = slot_e;
                        clr_d[slot_e] = 1'b1;
                    end
                end
                if (exc_head) begin
                    req_d  = 1'b1;
                    erid_d = head_q;
                end
            end
            ST_EXC_WAIT: begin
                if (bus.exc_ack_i) req_d = 1'b0;
            end
            ST_FLUSH: begin
                clr_d  = bus.rob_v_i;
                head_d = bus.rob_tail_i;
            end
            default: ;
        endcase
    end

    assign bus.rob_head_o   = head_q;
    assign bus.rob_clr_o    = clr_q;
    assign bus.commit_v_o   = cv_q;
    assign bus.commit_rid_o = rid_q;
    assign bus.commitCnt    = cnt_q;
    assign bus.exc_req_o    = req_q;
    assign bus.exc_rid_o    = erid_q;

`ifdef ROB_COMMIT_PERF_EN
    logic [63:0] total_q;

    // Running sum of the per-cycle retirement count, wrapping at 2^64.
    always_ff @(posedge clk) begin
        if (rst) total_q <= '0;
        else     total_q <= total_q + 64'(cnt_q);
    end

    assign bus.commit_total_o = total_q;
`endif

endmodule

// File: doc/rob_commit.md
# rob_commit

In-order retirement stage for the Gambit reorder buffer. Each cycle it examines up to RSLOTS consecutive ROB entries starting at the head pointer, retires those that are valid and done, clears their valid bits and advances the head. It consumes the ROB entries marked valid by the allocation stage (getRQueuedCount). On an excepting entry at the head it runs an exception handshake and flushes the buffer.

## Interface
- RENTRIES, 16, ROB entries; power of two.
- RSLOTS, 2, maximum retirements per cycle; 1..4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rob_v_i  in  RENTRIES  entry valid, from allocation stage.
- rob_done_i  in  RENTRIES  entry execution complete.
- rob_exc_i  in  RENTRIES  entry completed with exception; meaningful only when done.
- rob_tail_i  in  $clog2(RENTRIES)  next entry allocation will use.
- exc_ack_i  in  1  exception handler accepted the request.
- rob_head_o  out  $clog2(RENTRIES)  oldest unretired entry.
- rob_clr_o  out  RENTRIES  one-cycle mask; allocation clears these valid bits.
- commit_v_o  out  RSLOTS  slot k retired an entry this cycle.
- commit_rid_o  out  RSLOTS x $clog2(RENTRIES)  entry retired by slot k.
- commitCnt  out  3  number of retirements this cycle (0..RSLOTS).
- exc_req_o  out  1  exception pending at head.
- exc_rid_o  out  $clog2(RENTRIES)  excepting entry.

## Operation
- States: RUN, EXC_WAIT, FLUSH.
- RUN: for k = 0..RSLOTS-1, let e = (head+k) mod RENTRIES. Slot k retires if every slot before it retired and rob_v_i[e] && rob_done_i[e] && !rob_exc_i[e]. The first non-retiring slot ends the group.
- RUN, exception: the group ends at an entry with valid && done && exc. If that entry is at slot 0, go to EXC_WAIT with exc_rid_o = head. Otherwise retire the earlier slots this cycle; the exception is taken on the next cycle.
- Empty buffer (head == rob_tail_i && !rob_v_i[head]): nothing retires and the head holds.
- Head advances by commitCnt modulo RENTRIES. Wrap from RENTRIES-1 to 0 is seamless within one group.
- A group never crosses an invalid entry, so the head never passes the tail.
- EXC_WAIT: exc_req_o = 1 and exc_rid_o is held stable until exc_ack_i. No retirement occurs. On exc_ack_i go to FLUSH.
- FLUSH (one cycle): rob_clr_o = rob_v_i (all valid entries), head <= rob_tail_i, commitCnt = 0, then return to RUN.
- exc_req_o and exc_ack_i in the same cycle are legal; the ack is sampled only in EXC_WAIT.

## Timing
- All outputs are registered. Inputs sampled at edge N appear on outputs after edge N, valid throughout cycle N+1.
- rob_clr_o, commit_v_o and commitCnt are single-cycle pulses. Upstream must clear the valid bits by the following edge.
- Because of the registered clear, an entry retired at edge N is masked internally in cycle N+1 so it is never retired twice.
- Reset values: head 0, state RUN, rob_clr_o 0, commit_v_o 0, commit_rid_o 0, commitCnt 0, exc_req_o 0, exc_rid_o 0, performance counter 0.
- Reset in any state, including EXC_WAIT or FLUSH, returns to RUN on the next edge with all reset values and discards any pending exception.

## Configuration
- ROB_COMMIT_PERF_EN defined: adds output commit_total_o (64 bits), which accumulates commitCnt every cycle, wraps modulo 2^64 and resets to 0.
- ROB_COMMIT_PERF_EN undefined: neither the port nor the counter exists.

## Structure
- Shared package: Rid typedef (the ROB index type), RENTRIES and RSLOTS defaults, and the commit state enum.
- One sub-module, rob_commit_select: combinational group-selection logic, taking head, valid, done and exc and producing the retire mask, count and exception flag.
- The state machine, head register and output registers remain in rob_commit.

## Test plan
- Basic retire: head 0, entries 0–1 valid and done -> commit_v_o 2'b11, commitCnt 2, rob_clr_o bits 0–1, head 2.
- In-order stop: entry 0 not done, entry 1 done -> commitCnt 0, head holds at 0.
- Wrap: RENTRIES 16, head 15, entries 15 and 0 done -> commit_rid_o {15, 0}, head 1.
- Exception: head 3, entry 3 exc -> exc_req_o 1, exc_rid_o 3 held for 5 cycles; ack -> FLUSH clears all valid entries, head = rob_tail_i, RUN resumes.
- Exception at slot 1: entry 4 done, entry 5 exc -> entry 4 retires, then exc_req_o with exc_rid_o 5.
- Reset mid-EXC_WAIT -> next cycle exc_req_o 0, head 0, state RUN, no flush pulse.
